user_seq_capture: RTL and testbench

- Builds the player's input sequence for the Genius game from the four colour buttons, one 4-bit one-hot code per accepted press.
- Sits directly upstream of the 64-bit user sequence register. It drives that register's 64-bit data bus and its load enable.
- The register is loaded once, when the player has entered as many presses as the current round length.
- Also provides a per-press pulse for LED/sound feedback.

---
 rtl/user_seq_capture.sv | 124 ++++++++++++
 tb/tb_user_seq_capture.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_seq_capture.sv
// user_seq_capture
//   Turns debounced colour-button presses into the player's sequence for one
//   turn. Each accepted press shifts its one-hot code into DATA. DONE latches
//   and E_OUT pulses once the round length has been entered.
//
// Ports
//   CLK    system clock, rising edge
//   R      asynchronous active-low reset
//   CLR    synchronous clear at the start of each user turn
//   EN     user turn active; presses are accepted only while high
//   BTN    colour buttons, already synchronised to CLK (one-hot when valid)
//   LEVEL  presses expected this round (0 -> 1, >16 -> 16)
//   DATA   captured sequence; newest press in [3:0]
//   E_OUT  one-cycle load strobe for the downstream sequence register
//   PRESS  one-cycle pulse per accepted press
//   CNT    presses accepted since reset/CLR (0..16)
//   DONE   round length reached; held until CLR or reset
//
// State   | meaning
// RELEASE | waiting for all buttons released before a new press may start
// ARMED   | buttons released; the next one-hot code starts a debounce
// DEB     | counting consecutive edges with the captured code held
module user_seq_capture #(
  parameter int DEB_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        R,
  input  logic        CLR,
  input  logic        EN,
  input  logic [3:0]  BTN,
  input  logic [4:0]  LEVEL,
  output logic [63:0] DATA,
  output logic        E_OUT,
  output logic        PRESS,
  output logic [4:0]  CNT,
  output logic        DONE
);

  typedef enum logic [1:0] {RELEASE, ARMED, DEB} state_t;

  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  state_t      state;
  logic [15:0] deb_cnt;
  logic [3:0]  code;
  logic        btn_onehot;
  logic        btn_multi;
  logic [4:0]  lvl_eff;

  always_comb begin
    btn_onehot = (BTN != 4'd0) && ((BTN & (BTN - 4'd1)) == 4'd0);
    btn_multi  = (BTN != 4'd0) && !btn_onehot;
    if (LEVEL == 5'd0)
      lvl_eff = 5'd1;
    else if (LEVEL > 5'd16)
      lvl_eff = 5'd16;
    else
      lvl_eff = LEVEL;
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state   <= RELEASE;
      deb_cnt <= 16'd0;
      code    <= 4'd0;
      DATA    <= 64'd0;
      CNT     <= 5'd0;
      DONE    <= 1'b0;
      PRESS   <= 1'b0;
      E_OUT   <= 1'b0;
    end else begin
      PRESS <= 1'b0;
      E_OUT <= 1'b0;
      if (CLR) begin
        state   <= RELEASE;
        deb_cnt <= 16'd0;
        code    <= 4'd0;
        DATA    <= 64'd0;
        CNT     <= 5'd0;
        DONE    <= 1'b0;
      end else begin
        unique case (state)
          RELEASE: begin
            if (BTN == 4'd0)
              state <= ARMED;
          end
          ARMED: begin
            if (btn_onehot && EN && !DONE) begin
              code    <= BTN;
              deb_cnt <= 16'd1;
              state   <= DEB;
            end else if (btn_multi) begin
              state <= RELEASE;
            end
          end
          DEB: begin
            if (BTN == code && EN) begin
              if (deb_cnt == DEB_LAST) begin
                state <= RELEASE;
                // Past 16 presses the shift register is full; further
                // accepts are absorbed silently.
                if (CNT < 5'd16) begin
                  DATA  <= {DATA[59:0], code};
                  CNT   <= CNT + 5'd1;
                  PRESS <= 1'b1;
                  if (CNT + 5'd1 == lvl_eff) begin
                    DONE  <= 1'b1;
                    E_OUT <= 1'b1;
                  end
                end
              end else begin
                deb_cnt <= deb_cnt + 16'd1;
              end
            end else begin
              state <= RELEASE;
            end
          end
          default: state <= RELEASE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_user_seq_capture.sv
module tb_user_seq_capture;
  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        R, CLR, EN;
  logic [3:0]  BTN;
  logic [4:0]  LEVEL;
  logic [63:0] DATA;
  logic        E_OUT, PRESS, DONE;
  logic [4:0]  CNT;

  always #5 CLK = ~CLK;

  user_seq_capture #(.DEB_CYCLES(D)) dut (
    .CLK(CLK), .R(R), .CLR(CLR), .EN(EN), .BTN(BTN), .LEVEL(LEVEL),
    .DATA(DATA), .E_OUT(E_OUT), .PRESS(PRESS), .CNT(CNT), .DONE(DONE)
  );

  typedef struct {
    logic [63:0] data;
    int          cnt;
    bit          done;
    bit          eout;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0, n_fail = 0, n_press = 0, n_eout = 0;
  bit prev_press = 0;

  // Reference model: tracks the player's press history in plain terms.
  logic [63:0] m_data;
  int          m_cnt;
  bit          m_done;
  bit          m_wait_zero;   // a release must be seen before a new press
  logic [3:0]  m_code;
  int          m_run;         // edges the current code has been held (0 = none)

  function automatic int eff_level(input logic [4:0] lv);
    if (lv == 0) return 1;
    if (lv > 16) return 16;
    return int'(lv);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 0; m_cnt = 0; m_done = 0; m_wait_zero = 1; m_run = 0; m_code = 0;
  endtask

  task automatic model_accept();
    exp_t e;
    if (m_cnt >= 16) return;
    m_data = (m_data << 4) | 64'(m_code);
    m_cnt++;
    e.eout = (m_cnt == eff_level(LEVEL));
    if (e.eout) m_done = 1;
    e.data = m_data; e.cnt = m_cnt; e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic model_step();
    if (CLR) begin
      model_reset();
      return;
    end
    if (m_run > 0) begin
      if (BTN == m_code && EN) begin
        m_run++;
        if (m_run == D) begin
          m_run = 0; m_wait_zero = 1;
          model_accept();
        end
      end else begin
        m_run = 0; m_wait_zero = 1;
      end
    end else if (m_wait_zero) begin
      if (BTN == 0) m_wait_zero = 0;
    end else if ($countones(BTN) == 1 && EN && !m_done) begin
      m_code = BTN; m_run = 1;
    end else if ($countones(BTN) > 1) begin
      m_wait_zero = 1;
    end
  endtask

  task automatic drive(input logic [3:0] b, input bit en, input bit clr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      BTN = b; EN = en; CLR = clr;
      model_step();
      @(posedge CLK);
    end
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int idle);
    drive(4'd0, 1, 0, idle);
    drive(b, 1, 0, hold);
  endtask

  task automatic chk_model(input string name);
    #1;
    chk({name, " data"}, DATA, m_data);
    chk({name, " cnt"}, 64'(CNT), 64'(m_cnt));
    chk({name, " done"}, 64'(DONE), 64'(m_done));
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    exp_t e;
    if (R) begin
      if (PRESS) begin
        n_press++;
        if (E_OUT) n_eout++;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_press: PRESS=1 cnt=%0d, none expected", CNT);
        end else begin
          e = sb.pop_front();
          chk("press data", DATA, e.data);
          chk("press cnt", 64'(CNT), 64'(e.cnt));
          chk("press done", 64'(DONE), 64'(e.done));
          chk("press eout", 64'(E_OUT), 64'(e.eout));
        end
      end else begin
        if (E_OUT) n_eout++;
        chk("eout without press", 64'(E_OUT), 64'd0);
      end
      chk("press width", 64'(prev_press & PRESS), 64'd0);
      prev_press = PRESS;
    end
  end

  int p0, e0;
  logic [3:0] rb;
  bit ren, rclr;

  initial begin
    R = 0; CLR = 0; EN = 0; BTN = 0; LEVEL = 3;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst data", DATA, 64'd0);
    chk("rst cnt", 64'(CNT), 64'd0);
    chk("rst done", 64'(DONE), 64'd0);
    chk("rst press", 64'(PRESS), 64'd0);
    chk("rst eout", 64'(E_OUT), 64'd0);
    R = 1;

    // Basic three-press round
    drive(4'd0, 1, 1, 1);
    p0 = n_press; e0 = n_eout;
    press(4'b0001, 6, 3);
    press(4'b0100, 6, 3);
    press(4'b1000, 6, 3);
    drive(4'd0, 1, 0, 2);
    chk_model("round3");
    chk("round3 data", DATA, 64'h148);
    chk("round3 cnt", 64'(CNT), 64'd3);
    chk("round3 done", 64'(DONE), 64'd1);
    chk("round3 presses", 64'(n_press - p0), 64'd3);
    chk("round3 eouts", 64'(n_eout - e0), 64'd1);
    press(4'b0010, 6, 3);
    drive(4'd0, 1, 0, 2);
    chk_model("after done");
    chk("after done data", DATA, 64'h148);
    chk("after done presses", 64'(n_press - p0), 64'd3);

    // Glitch rejection
    drive(4'd0, 1, 1, 1);
    p0 = n_press;
    drive(4'd0, 1, 0, 2);
    drive(4'b0010, 1, 0, 3);
    drive(4'd0, 1, 0, 2);
    chk_model("short glitch");
    chk("short glitch presses", 64'(n_press - p0), 64'd0);
    drive(4'b0011, 1, 0, 10);
    drive(4'd0, 1, 0, 2);
    chk("multi presses", 64'(n_press - p0), 64'd0);
    drive(4'b0010, 1, 0, 4);
    drive(4'd0, 1, 0, 2);
    chk_model("glitch accept");
    chk("glitch accept nibble", DATA & 64'hF, 64'h2);
    chk("glitch accept cnt", 64'(CNT), 64'd1);

    // Held button and EN drop
    drive(4'd0, 1, 1, 1);
    p0 = n_press;
    drive(4'd0, 1, 0, 2);
    drive(4'b0100, 1, 0, 50);
    drive(4'd0, 1, 0, 2);
    chk("hold presses", 64'(n_press - p0), 64'd1);
    chk("hold cnt", 64'(CNT), 64'd1);
    drive(4'b0001, 1, 0, 2);
    drive(4'b0001, 0, 0, 1);
    drive(4'b0001, 1, 0, 5);
    drive(4'd0, 1, 0, 2);
    chk_model("en drop");
    chk("en drop presses", 64'(n_press - p0), 64'd1);

    // Full length, LEVEL 16 and clamped 20
    for (int k = 0; k < 2; k++) begin
      LEVEL = (k == 0) ? 5'd16 : 5'd20;
      drive(4'd0, 1, 1, 1);
      e0 = n_eout;
      for (int i = 0; i < 16; i++) press(4'(1 << (i % 4)), 5, 2);
      drive(4'd0, 1, 0, 2);
      chk_model("full");
      chk("full data", DATA, 64'h1248_1248_1248_1248);
      chk("full cnt", 64'(CNT), 64'd16);
      chk("full eouts", 64'(n_eout - e0), 64'd1);
    end

    // LEVEL 0 behaves as 1
    LEVEL = 0;
    drive(4'd0, 1, 1, 1);
    e0 = n_eout;
    press(4'b1000, 5, 2);
    drive(4'd0, 1, 0, 2);
    chk("lvl0 data", DATA, 64'h8);
    chk("lvl0 done", 64'(DONE), 64'd1);
    chk("lvl0 eouts", 64'(n_eout - e0), 64'd1);

    // Async reset mid-debounce
    LEVEL = 3;
    drive(4'd0, 1, 1, 1);
    press(4'b0010, 5, 2);
    drive(4'd0, 1, 0, 2);
    drive(4'b0001, 1, 0, 2);
    #3 R = 0;
    model_reset();
    #1;
    chk("async data", DATA, 64'd0);
    chk("async cnt", 64'(CNT), 64'd0);
    chk("async done", 64'(DONE), 64'd0);
    chk("async press", 64'(PRESS), 64'd0);
    R = 1;
    p0 = n_press;
    drive(4'b0001, 1, 0, 8);
    chk("held after reset", 64'(n_press - p0), 64'd0);
    press(4'b0001, 5, 2);
    drive(4'd0, 1, 0, 2);
    chk_model("after reset");
    chk("after reset cnt", 64'(CNT), 64'd1);

    // CLR on the accept edge
    LEVEL = 1;
    drive(4'd0, 1, 1, 1);
    p0 = n_press; e0 = n_eout;
    drive(4'd0, 1, 0, 2);
    drive(4'b0001, 1, 0, 3);
    drive(4'b0001, 1, 1, 1);
    drive(4'd0, 1, 0, 3);
    chk_model("clr accept");
    chk("clr accept cnt", 64'(CNT), 64'd0);
    chk("clr accept presses", 64'(n_press - p0), 64'd0);
    chk("clr accept eouts", 64'(n_eout - e0), 64'd0);

    // Randomized traffic against the model
    LEVEL = 5'($urandom_range(0, 20));
    drive(4'd0, 1, 1, 1);
    for (int s = 0; s < 500; s++) begin
      int kind, hold;
      if ($urandom_range(0, 9) == 0) LEVEL = 5'($urandom_range(0, 20));
      kind = $urandom_range(0, 9);
      if (kind < 4)      rb = 4'd0;
      else if (kind < 8) rb = 4'(1 << $urandom_range(0, 3));
      else               rb = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 6);
      ren  = ($urandom_range(0, 9) != 0);
      rclr = ($urandom_range(0, 39) == 0);
      drive(rb, ren, rclr, 1);
      drive(rb, ren, 0, hold - 1);
      if (s % 25 == 24) chk_model("random");
    end

    drive(4'd0, 1, 0, 3);
    chk_model("final");
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
